// File: rtl/spi_frame_assembler_if.sv
// Push-bus bundle between the SPI receive side, the frame assembler and the 1553 transmit side.
// The slave modport is the assembler's view; the master modport is the surrounding environment's view.
interface spi_frame_assembler_if;
  logic [15:0] in_data;
  logic        in_request;
  logic        in_done;
  logic [15:0] out_data;
  logic        out_request;
  logic        out_done;

  modport master (
    output in_data, in_request, out_done,
    input  in_done, out_data, out_request
  );

  modport slave (
    input  in_data, in_request, out_done,
    output in_done, out_data, out_request
  );
endinterface

// File: rtl/spi_frame_assembler.sv
// Collects SPI words into length-prefixed frames, validates address/size/checksum and replays good frames.
// Optional inter-word timeout is built only when SPI_FRAME_TIMEOUT_EN is defined.
module spi_frame_assembler #(
  parameter int         DEPTH    = 32,
  parameter logic [7:0] OWN_ADDR = 8'h01,
  parameter int         TIMEOUT  = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  spi_frame_assembler_if.slave        bus,
  output logic                        busy,
  output logic                        frame_ok,
  output logic                        err_csum,
  output logic                        err_size,
  output logic                        err_timeout
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_W = 8'(DEPTH);

  typedef enum logic [2:0] {
    ST_HEAD    = 3'd0,
    ST_DATA    = 3'd1,
    ST_CSUM    = 3'd2,
    ST_SEND    = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  state_t      state_q;
  logic        in_done_q;
  logic        out_req_q;
  logic [15:0] out_data_q;
  logic [15:0] hdr_q;
  logic [15:0] sum_q;
  logic [7:0]  size_q;
  logic [7:0]  idx_q;
  logic [8:0]  remain_q;
  logic [8:0]  send_cnt_q;
  logic        frame_ok_q;
  logic        err_csum_q;
  logic        err_size_q;
  logic [15:0] mem_q [DEPTH];

  logic        take_s;
  logic        wr_s;
  logic [7:0]  haddr_s;
  logic [7:0]  hsize_s;
  logic [8:0]  rd_s;

  assign take_s  = bus.in_request && !in_done_q && (state_q != ST_SEND);
  assign wr_s    = take_s && (state_q == ST_DATA);
  assign haddr_s = bus.in_data[15:8];
  assign hsize_s = bus.in_data[7:0];
  assign rd_s    = send_cnt_q - 9'd1;

`ifdef SPI_FRAME_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
  logic [15:0] timer_q;
  logic        err_timeout_q;
  logic        timeout_s;

  assign timeout_s = !take_s && (timer_q == TIMEOUT_W) &&
                     ((state_q == ST_DATA) || (state_q == ST_CSUM) || (state_q == ST_DISCARD));
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = (TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

  // Frame FSM with registered handshake, data and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_HEAD;
      in_done_q  <= 1'b0;
      out_req_q  <= 1'b0;
      out_data_q <= 16'h0000;
      hdr_q      <= 16'h0000;
      sum_q      <= 16'h0000;
      size_q     <= 8'd0;
      idx_q      <= 8'd0;
      remain_q   <= 9'd0;
      send_cnt_q <= 9'd0;
      frame_ok_q <= 1'b0;
      err_csum_q <= 1'b0;
      err_size_q <= 1'b0;
`ifdef SPI_FRAME_TIMEOUT_EN
      timer_q       <= 16'd0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      in_done_q  <= take_s;
      frame_ok_q <= 1'b0;
      err_csum_q <= 1'b0;
      err_size_q <= 1'b0;
`ifdef SPI_FRAME_TIMEOUT_EN
      err_timeout_q <= 1'b0;
      if (take_s || (state_q == ST_HEAD) || (state_q == ST_SEND)) begin
        timer_q <= 16'd0;
      end else begin
        timer_q <= timer_q + 16'd1;
      end
      if (timeout_s) begin
        err_timeout_q <= 1'b1;
        state_q       <= ST_HEAD;
      end else
`endif
      case (state_q)
        ST_HEAD: begin
          if (take_s) begin
            hdr_q  <= bus.in_data;
            sum_q  <= bus.in_data;
            size_q <= hsize_s;
            idx_q  <= 8'd0;
            if (hsize_s == 8'd0) begin
              err_size_q <= 1'b1;
            end else if (hsize_s > DEPTH_W) begin
              err_size_q <= 1'b1;
              remain_q   <= {1'b0, hsize_s} + 9'd1;
              state_q    <= ST_DISCARD;
            end else if ((haddr_s != OWN_ADDR) && (haddr_s != 8'hFF)) begin
              remain_q <= {1'b0, hsize_s} + 9'd1;
              state_q  <= ST_DISCARD;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (take_s) begin
            sum_q <= sum_q + bus.in_data;
            idx_q <= idx_q + 8'd1;
            if (idx_q == (size_q - 8'd1)) begin
              state_q <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          // A good checksum launches the header onto the outbound bus in the same edge.
          if (take_s) begin
            if (bus.in_data == sum_q) begin
              frame_ok_q <= 1'b1;
              out_req_q  <= 1'b1;
              out_data_q <= hdr_q;
              send_cnt_q <= 9'd0;
              state_q    <= ST_SEND;
            end else begin
              err_csum_q <= 1'b1;
              state_q    <= ST_HEAD;
            end
          end
        end
        ST_SEND: begin
          if (out_req_q) begin
            if (bus.out_done) begin
              out_req_q  <= 1'b0;
              send_cnt_q <= send_cnt_q + 9'd1;
              if (send_cnt_q == {1'b0, size_q}) begin
                state_q <= ST_HEAD;
              end
            end
          end else begin
            out_req_q  <= 1'b1;
            out_data_q <= mem_q[rd_s[AW-1:0]];
          end
        end
        ST_DISCARD: begin
          if (take_s) begin
            remain_q <= remain_q - 9'd1;
            if (remain_q == 9'd1) begin
              state_q <= ST_HEAD;
            end
          end
        end
        default: begin
          state_q <= ST_HEAD;
        end
      endcase
    end
  end

  // Frame payload buffer; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_s && !rst) begin
      mem_q[idx_q[AW-1:0]] <= bus.in_data;
    end
  end

  assign bus.in_done     = in_done_q;
  assign bus.out_request = out_req_q;
  assign bus.out_data    = out_data_q;
  assign busy            = (state_q != ST_HEAD);
  assign frame_ok        = frame_ok_q;
  assign err_csum        = err_csum_q;
  assign err_size        = err_size_q;

endmodule

// File: tb/tb_spi_frame_assembler.sv
// Randomized self-checking bench for spi_frame_assembler; a word-stream frame parser predicts pulses and output.
module tb_spi_frame_assembler;
  localparam int         DEPTH = 32;
  localparam logic [7:0] OWN   = 8'h01;
`ifdef SPI_FRAME_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  localparam int EV_OK = 0, EV_CSUM = 1, EV_SIZE = 2, EV_TO = 3;

  logic clk = 1'b0;
  logic rst;
  logic busy, frame_ok, err_csum, err_size, err_timeout;
  always #5 clk = ~clk;

  spi_frame_assembler_if ifc();

  spi_frame_assembler #(.DEPTH(DEPTH), .OWN_ADDR(OWN), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(ifc), .busy(busy), .frame_ok(frame_ok),
    .err_csum(err_csum), .err_size(err_size), .err_timeout(err_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] stim[$], exp_out[$], got_out[$];
  int exp_ev[$], got_ev[$];
  bit multi_pulse = 1'b0;
  int sink_min = 0, sink_max = 0, sink_wait = 0;
  bit spurious_en = 1'b0;
  int gap_max = 0;
  logic snap_ok, snap_csum, snap_size, snap_oreq, snap_busy;
  logic [15:0] snap_odata;

  // Outbound sink: records each accepted word and answers with a one-cycle out_done.
  initial begin
    ifc.out_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ifc.out_done) begin
        ifc.out_done = 1'b0;
      end else if (ifc.out_request && !rst) begin
        if (sink_wait == 0) begin
          got_out.push_back(ifc.out_data);
          ifc.out_done = 1'b1;
          sink_wait = $urandom_range(sink_max, sink_min);
        end else begin
          sink_wait--;
        end
      end else if (spurious_en && ($urandom_range(3, 0) == 0)) begin
        ifc.out_done = 1'b1;
      end
    end
  end

  // Status pulse monitor.
  initial begin
    int np;
    forever begin
      @(negedge clk);
      np = int'(frame_ok) + int'(err_csum) + int'(err_size) + int'(err_timeout);
      if (np > 1) multi_pulse = 1'b1;
      if (frame_ok)    got_ev.push_back(EV_OK);
      if (err_csum)    got_ev.push_back(EV_CSUM);
      if (err_size)    got_ev.push_back(EV_SIZE);
      if (err_timeout) got_ev.push_back(EV_TO);
    end
  end

  task automatic set_sink(input int mn, input int mx, input bit sp);
    sink_min = mn; sink_max = mx; sink_wait = mn; spurious_en = sp;
  endtask

  task automatic send_word(input logic [15:0] w);
    bit seen = 1'b0;
    ifc.in_data = w;
    ifc.in_request = 1'b1;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (ifc.in_done) begin
        seen = 1'b1;
        snap_ok = frame_ok; snap_csum = err_csum; snap_size = err_size;
        snap_oreq = ifc.out_request; snap_odata = ifc.out_data; snap_busy = busy;
      end
    end
    ifc.in_request = 1'b0;
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL in_accept: no in_done for word %h, expected within 3000 cycles", w);
    end
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int k = 0; k < 5000 && !idle; k++) begin
      @(negedge clk);
      if (!busy && !ifc.out_request) idle = 1'b1;
    end
    if (!idle) begin
      n_tests++; n_fail++;
      $display("FAIL drain: busy=%b out_request=%b, expected idle within 5000 cycles", busy, ifc.out_request);
    end
    repeat (2) @(negedge clk);
  endtask

  // Reference: parse the word stream frame by frame and predict pulses and forwarded words.
  task automatic model();
    int i = 0;
    logic [15:0] hdr, sum;
    int sz;
    logic [7:0] ad;
    exp_ev.delete(); exp_out.delete();
    while (i < stim.size()) begin
      hdr = stim[i]; i++;
      sz = int'(hdr[7:0]); ad = hdr[15:8];
      if (sz == 0) begin
        exp_ev.push_back(EV_SIZE);
      end else if (sz > DEPTH) begin
        exp_ev.push_back(EV_SIZE);
        i += sz + 1;
      end else if (ad != OWN && ad != 8'hFF) begin
        i += sz + 1;
      end else begin
        sum = hdr;
        for (int k = 0; k < sz; k++) sum = sum + stim[i + k];
        if (stim[i + sz] == sum) begin
          exp_ev.push_back(EV_OK);
          exp_out.push_back(hdr);
          for (int k = 0; k < sz; k++) exp_out.push_back(stim[i + k]);
        end else begin
          exp_ev.push_back(EV_CSUM);
        end
        i += sz + 1;
      end
    end
  endtask

  task automatic run_stream(input string name);
    got_ev.delete(); got_out.delete();
    model();
    foreach (stim[i]) begin
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      send_word(stim[i]);
    end
    drain();
    n_tests++;
    if (got_ev.size() !== exp_ev.size())
      $display("FAIL %s_ev_count: got %0d expected %0d", name, got_ev.size(), exp_ev.size());
    if (got_ev.size() !== exp_ev.size()) n_fail++;
    for (int i = 0; i < exp_ev.size() && i < got_ev.size(); i++) begin
      n_tests++;
      if (got_ev[i] !== exp_ev[i]) begin
        n_fail++;
        $display("FAIL %s_ev[%0d]: got %0d expected %0d", name, i, got_ev[i], exp_ev[i]);
      end
    end
    n_tests++;
    if (got_out.size() !== exp_out.size()) begin
      n_fail++;
      $display("FAIL %s_out_count: got %0d expected %0d", name, got_out.size(), exp_out.size());
    end
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++) begin
      n_tests++;
      if (got_out[i] !== exp_out[i]) begin
        n_fail++;
        $display("FAIL %s_out[%0d]: got %h expected %h", name, i, got_out[i], exp_out[i]);
      end
    end
    n_tests++;
    if (multi_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_one_pulse: got overlapping pulses expected at most one per cycle", name);
      multi_pulse = 1'b0;
    end
  endtask

  task automatic good_frame();
    stim = '{16'h0102, 16'h1111, 16'h2222, 16'h3435};
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs = {ifc.in_done, ifc.out_request, ifc.out_data, busy, frame_ok, err_csum, err_size, err_timeout};
    n_tests++;
    if (obs !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_frame();
    set_sink(0, 2, 1'b0);
    good_frame();
    run_stream("good");
    n_tests++;
    if ({snap_ok, snap_oreq, snap_odata} !== {1'b1, 1'b1, 16'h0102}) begin
      n_fail++;
      $display("FAIL good_timing: got ok=%b oreq=%b odata=%h expected 1 1 0102", snap_ok, snap_oreq, snap_odata);
    end
  endtask

  task automatic test_bad_csum();
    set_sink(0, 1, 1'b0);
    stim = '{16'h0102, 16'h1111, 16'h2222, 16'h3436};
    run_stream("bad_csum");
    n_tests++;
    if ({snap_csum, snap_oreq} !== 2'b10) begin
      n_fail++;
      $display("FAIL bad_csum_timing: got csum=%b oreq=%b expected 1 0", snap_csum, snap_oreq);
    end
    good_frame();
    run_stream("after_bad");
  endtask

  task automatic test_size_limits();
    set_sink(0, 1, 1'b0);
    stim = '{16'h0100};
    run_stream("size0");
    n_tests++;
    if ({snap_size, snap_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL size0_state: got err_size=%b busy=%b expected 1 0", snap_size, snap_busy);
    end
    stim = '{16'h0121};
    for (int i = 0; i < 34; i++) stim.push_back(16'($urandom));
    stim.push_back(16'h0102); stim.push_back(16'h1111);
    stim.push_back(16'h2222); stim.push_back(16'h3435);
    run_stream("oversize");
    // Largest legal frame fills the whole buffer.
    stim = '{16'hFF20};
    for (int i = 0; i < DEPTH; i++) stim.push_back(16'($urandom));
    stim.push_back(16'($urandom));
    model();
    stim[stim.size() - 1] = exp_out.size() > 0 ? stim[stim.size() - 1] : 16'h0000;
    begin
      logic [15:0] s = 16'hFF20;
      for (int i = 1; i <= DEPTH; i++) s = s + stim[i];
      stim[DEPTH + 1] = s;
    end
    run_stream("full_depth");
  endtask

  task automatic test_foreign_broadcast();
    set_sink(0, 2, 1'b1);
    stim = '{16'h0501, 16'h1234, 16'h5678, 16'hFF01, 16'h00AA, 16'h00AB};
    run_stream("addr");
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    set_sink(10, 10, 1'b0);
    got_ev.delete(); got_out.delete();
    good_frame();
    foreach (stim[i]) send_word(stim[i]);
    ifc.in_data = 16'h0100;
    ifc.in_request = 1'b1;
    for (int k = 0; k < 2000 && !seen; k++) begin
      @(negedge clk);
      if (ifc.in_done) seen = 1'b1;
    end
    ifc.in_request = 1'b0;
    n_tests++;
    if (!seen || got_out.size() != 3) begin
      n_fail++;
      $display("FAIL backpressure: in_done seen=%b after %0d words sent, expected 1 after 3", seen, got_out.size());
    end
    drain();
    n_tests++;
    if (got_ev.size() != 2 || got_ev[0] != EV_OK || got_ev[1] != EV_SIZE) begin
      n_fail++;
      $display("FAIL backpressure_ev: got %0d events expected ok then size", got_ev.size());
    end
    n_tests++;
    if (got_out.size() != 3 || got_out[2] !== 16'h2222) begin
      n_fail++;
      $display("FAIL backpressure_out: got %0d words expected 0102 1111 2222", got_out.size());
    end
  endtask

  task automatic test_random();
    int kind, sz;
    logic [15:0] sum, w;
    logic [7:0] ad;
    set_sink(0, 3, 1'b1);
    gap_max = 3;
    stim.delete();
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(9, 0);
      sz = (kind == 4) ? DEPTH : $urandom_range(8, 1);
      ad = ($urandom_range(1, 0) == 1) ? 8'hFF : OWN;
      if (kind == 0) begin
        stim.push_back({OWN, 8'h00});
      end else if (kind == 1) begin
        sz = $urandom_range(40, DEPTH + 1);
        stim.push_back({OWN, 8'(sz)});
        for (int k = 0; k <= sz; k++) stim.push_back(16'($urandom));
      end else begin
        if (kind == 2) ad = 8'($urandom_range(254, 2));
        sum = {ad, 8'(sz)};
        stim.push_back(sum);
        for (int k = 0; k < sz; k++) begin
          w = 16'($urandom);
          stim.push_back(w);
          sum = sum + w;
        end
        stim.push_back((kind == 3) ? sum + 16'd1 : sum);
      end
    end
    run_stream("random");
    gap_max = 0;
  endtask

`ifdef SPI_FRAME_TIMEOUT_EN
  task automatic test_timeout();
    set_sink(0, 1, 1'b0);
    got_ev.delete();
    send_word(16'h0102);
    repeat (20) @(negedge clk);
    n_tests++;
    if (got_ev.size() != 1 || got_ev[0] != EV_TO || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: got %0d events busy=%b expected one err_timeout busy=0", got_ev.size(), busy);
    end
    good_frame();
    run_stream("after_timeout");
  endtask
`endif

  task automatic test_reset_mid();
    logic [22:0] obs;
    set_sink(10, 10, 1'b0);
    got_ev.delete();
    send_word(16'h0103);
    send_word(16'h4444);
    rst = 1'b1;
    @(negedge clk);
    obs = {ifc.in_done, ifc.out_request, ifc.out_data, busy, frame_ok, err_csum, err_size, err_timeout};
    n_tests++;
    if (obs !== 23'd0 || got_ev.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_data: got %h events=%0d expected 0 0", obs, got_ev.size());
    end
    rst = 1'b0;
    @(negedge clk);
    good_frame();
    foreach (stim[i]) send_word(stim[i]);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({ifc.out_request, busy, ifc.out_data} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_mid_send: got oreq=%b busy=%b odata=%h expected 0 0 0000", ifc.out_request, busy, ifc.out_data);
    end
    rst = 1'b0;
    @(negedge clk);
    set_sink(0, 2, 1'b0);
    good_frame();
    run_stream("after_reset");
  endtask

  initial begin
    ifc.in_data = 16'h0000;
    ifc.in_request = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_size_limits();
    test_foreign_broadcast();
    test_backpressure();
    test_random();
`ifdef SPI_FRAME_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
